// File: rtl/instr_fetch_unit_if.sv
// Memory-side request/response bus of the instruction fetch unit.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word-addressed PC generation, one outstanding memory request,
// in-order prefetch queue and redirect flush. Define FETCH_BYPASS_EN to forward a response
// straight to the core when the queue is empty.
module instr_fetch_unit #(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master mem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [DW-1:0]      instr_data,
    output logic [AW-1:0]      instr_pc,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    output logic               busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   req_pc;
    logic [AW-1:0]   pc_q   [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_n;
    logic            req_valid_q;
    logic            busy_q;
    logic            hs, push, pop, head_valid, bypass_c;

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = fetch_pc;
    assign busy              = busy_q;

    assign hs         = req_valid_q && mem.mem_req_ready;
    assign head_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_c = (state == S_WAIT) && !head_valid && mem.mem_rsp_valid
                      && instr_ready && !redirect_valid;
`else
    assign bypass_c = 1'b0;
`endif

    // Redirect suppresses both queue ports; a bypassed response never enters the queue.
    assign pop  = head_valid && instr_ready && !redirect_valid;
    assign push = (state == S_WAIT) && mem.mem_rsp_valid && !bypass_c && !redirect_valid;

    assign instr_valid = head_valid || bypass_c;
    assign instr_data  = bypass_c ? mem.mem_rsp_data : (head_valid ? data_q[rd_ptr] : '0);
    assign instr_pc    = bypass_c ? req_pc           : (head_valid ? pc_q[rd_ptr]   : '0);

    // Next state and occupancy; a request left in flight by a redirect is drained in DROP.
    always_comb begin
        state_n = state;
        count_n = count;
        if (redirect_valid) begin
            count_n = '0;
            if (hs || (state != S_REQ && !mem.mem_rsp_valid)) state_n = S_DROP;
            else                                              state_n = S_REQ;
        end else begin
            case (state)
                S_REQ:          if (hs) state_n = S_WAIT;
                S_WAIT, S_DROP: if (mem.mem_rsp_valid) state_n = S_REQ;
                default:        state_n = S_REQ;
            endcase
            count_n = count + CW'(push) - CW'(pop);
        end
    end

    // Control registers; request valid is registered from the next state so it never
    // depends combinationally on mem_req_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            req_valid_q <= (state_n == S_REQ) && (count_n < CW'(DEPTH));
            busy_q      <= (state_n != S_REQ);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (hs) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + AW'(1);
                end
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Queue storage; only reachable through count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_q[wr_ptr]   <= req_pc;
            data_q[wr_ptr] <= mem.mem_rsp_data;
        end
    end
endmodule
